// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a low column across the keypad, snapshots
// the rows into a 16-bit frame, and debounces presses/releases across whole frames.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] value,
  output logic       key_flag,
  output logic       key_held
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    REL_CHK
  } state_e;

  // Frame bit index {row, col} to key code.
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    key_code = 4'h1;
      4'd1:    key_code = 4'h2;
      4'd2:    key_code = 4'h3;
      4'd3:    key_code = 4'hA;
      4'd4:    key_code = 4'h4;
      4'd5:    key_code = 4'h5;
      4'd6:    key_code = 4'h6;
      4'd7:    key_code = 4'hB;
      4'd8:    key_code = 4'h7;
      4'd9:    key_code = 4'h8;
      4'd10:   key_code = 4'h9;
      4'd11:   key_code = 4'hC;
      4'd12:   key_code = 4'hE;
      4'd13:   key_code = 4'h0;
      4'd14:   key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
  endfunction

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        col_q, col_d;
  logic [15:0]       frame_q, frame_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        value_q, value_d;
  logic              flag_q, flag_d;
  logic              held_q, held_d;
  state_e            state_q, state_d;

  logic              sample_c;
  logic              frame_end_c;
  logic [15:0]       frame_now_c;
  logic [4:0]        hits_c;
  logic [3:0]        hit_idx_c;
  logic              none_c;
  logic              single_c;
  logic [3:0]        code_c;

  assign sample_c    = (slot_q == SLOT_LAST);
  assign frame_end_c = sample_c && (col_idx_q == 2'd3);

  // Snapshot including the rows of the column currently driven.
  always_comb begin
    frame_now_c = frame_q;
    for (int r = 0; r < 4; r++) begin
      frame_now_c[{r[1:0], col_idx_q}] = ~row[r];
    end
  end

  // Classify the frame: count of set bits and position of the last one.
  always_comb begin
    hits_c    = '0;
    hit_idx_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_now_c[i]) begin
        hits_c    = hits_c + 5'd1;
        hit_idx_c = 4'(i);
      end
    end
  end

  assign none_c   = (hits_c == 5'd0);
  assign single_c = (hits_c == 5'd1);
  assign code_c   = key_code(hit_idx_c);

  always_comb begin
    slot_d    = slot_q + SLOT_W'(1);
    col_idx_d = col_idx_q;
    col_d     = col_q;
    frame_d   = frame_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    value_d   = value_q;
    flag_d    = 1'b0;
    held_d    = held_q;

    if (sample_c) begin
      slot_d    = '0;
      col_idx_d = col_idx_q + 2'd1;
      col_d     = ~(4'(1) << col_idx_d);
      frame_d   = frame_end_c ? 16'h0000 : frame_now_c;
    end

    if (frame_end_c) begin
      case (state_q)
        IDLE: begin
          if (single_c) begin
            if (DEB_LAST == 4'd1) begin
              value_d = code_c;
              flag_d  = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = PRESSED;
            end else begin
              cand_d  = code_c;
              cnt_d   = 4'd1;
              state_d = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (single_c && (code_c == cand_q)) begin
            if (cnt_q + 4'd1 == DEB_LAST) begin
              value_d = cand_q;
              flag_d  = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = PRESSED;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (single_c) begin
            cand_d = code_c;
            cnt_d  = 4'd1;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        PRESSED: begin
          // Extra keys while held (rollover) never re-trigger.
          if (none_c) begin
            if (DEB_LAST == 4'd1) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d   = 4'd1;
              state_d = REL_CHK;
            end
          end
        end
        REL_CHK: begin
          if (none_c) begin
            if (cnt_q + 4'd1 == DEB_LAST) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d   = '0;
            state_d = PRESSED;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_q    <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
      frame_q   <= '0;
      cnt_q     <= '0;
      cand_q    <= '0;
      value_q   <= 4'h0;
      flag_q    <= 1'b0;
      held_q    <= 1'b0;
      state_q   <= IDLE;
    end else begin
      slot_q    <= slot_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      value_q   <= value_d;
      flag_q    <= flag_d;
      held_q    <= held_d;
      state_q   <= state_d;
    end
  end

  assign col      = col_q;
  assign value    = value_q;
  assign key_flag = flag_q;
  assign key_held = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates a physical keypad on row/col and checks
// every cycle against a frame-level model of the press/release debounce rules.
module tb_keypad_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DF = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  value;
  logic        key_flag;
  logic        key_held;
  logic [15:0] keys_down = 16'h0000;

  int checks = 0;
  int failures = 0;
  int flags_seen = 0;

  // Model state
  int unsigned n;
  logic [15:0] m_frame;
  bit          m_held;
  int          m_run;
  int          m_empty;
  logic [3:0]  m_code;
  logic [3:0]  e_value;
  logic [3:0]  e_col;
  bit          e_flag;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .value    (value),
    .key_flag (key_flag),
    .key_held (key_held)
  );

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && keys_down[4*r+c]) row[r] = 1'b0;
  end

  function automatic logic [3:0] code_at(input int idx);
    logic [15:0] codes;
    case (idx / 4)
      0:       codes = 16'h123A;
      1:       codes = 16'h456B;
      2:       codes = 16'h789C;
      default: codes = 16'hE0FD;
    endcase
    code_at = codes[15 - 4*(idx % 4) -: 4];
  endfunction

  task automatic judge(input logic [15:0] f);
    int cnt;
    int idx;
    logic [3:0] k;
    cnt = $countones(f);
    idx = 0;
    for (int i = 0; i < 16; i++) if (f[i]) idx = i;
    if (!m_held) begin
      if (cnt == 1) begin
        k = code_at(idx);
        if (m_run > 0 && k == m_code) m_run++;
        else begin
          m_run  = 1;
          m_code = k;
        end
        if (m_run == DF) begin
          m_held  = 1;
          e_value = k;
          e_flag  = 1;
          m_run   = 0;
          m_empty = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (cnt == 0) begin
        m_empty++;
        if (m_empty == DF) begin
          m_held  = 0;
          m_empty = 0;
          m_run   = 0;
        end
      end else begin
        m_empty = 0;
      end
    end
  endtask

  task automatic model_edge();
    int unsigned slot;
    int unsigned c;
    if (!rst) begin
      n = 0; m_frame = '0; m_held = 0; m_run = 0; m_empty = 0;
      m_code = '0; e_value = 4'h0; e_flag = 0;
    end else begin
      e_flag = 0;
      slot = n % SD;
      c = (n / SD) % 4;
      if (slot == SD - 1) begin
        for (int r = 0; r < 4; r++) if (keys_down[4*r+c]) m_frame[4*r+c] = 1'b1;
        if (c == 3) begin
          judge(m_frame);
          m_frame = '0;
        end
      end
      n++;
    end
    e_col = ~(4'(1) << ((n / SD) % 4));
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("col", 16'(col), 16'(e_col));
    chk("value", 16'(value), 16'(e_value));
    chk("key_flag", 16'(key_flag), 16'(e_flag));
    chk("key_held", 16'(key_held), 16'(m_held));
    if (key_flag === 1'b1) flags_seen++;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int w;

    // 1. Reset and column walk
    rst = 1'b0;
    keys_down = '0;
    run(5);
    chk("rst_col", 16'(col), 16'h000E);
    chk("rst_value", 16'(value), 16'h0);
    chk("rst_flag", 16'(key_flag), 16'h0);
    chk("rst_held", 16'(key_held), 16'h0);
    rst = 1'b1;
    run(4);
    chk("walk_col1", 16'(col), 16'h000D);
    run(4);
    chk("walk_col2", 16'(col), 16'h000B);
    run(4);
    chk("walk_col3", 16'(col), 16'h0007);
    run(4);
    chk("walk_col0", 16'(col), 16'h000E);

    // 2. Clean press of "5"
    f0 = flags_seen;
    keys_down = 16'(1) << 5;
    run(8 * 16);
    chk("t2_flags", 16'(flags_seen - f0), 16'd1);
    chk("t2_value", 16'(value), 16'h5);
    chk("t2_held", 16'(key_held), 16'h1);
    keys_down = '0;
    run(5 * 16);
    chk("t2_released", 16'(key_held), 16'h0);

    // 3. Bouncing "#"
    f0 = flags_seen;
    for (int i = 0; i < 10; i++) begin
      keys_down[14] = ~keys_down[14];
      run(20);
    end
    chk("t3_bounce_flags", 16'(flags_seen - f0), 16'd0);
    keys_down = 16'(1) << 14;
    run(6 * 16);
    chk("t3_flags", 16'(flags_seen - f0), 16'd1);
    chk("t3_value", 16'(value), 16'hF);
    keys_down = '0;
    run(5 * 16);

    // 4. Multi-key "1"+"9", then "1" alone
    f0 = flags_seen;
    keys_down = (16'(1) << 0) | (16'(1) << 10);
    run(6 * 16);
    chk("t4_multi_flags", 16'(flags_seen - f0), 16'd0);
    chk("t4_multi_value", 16'(value), 16'hF);
    keys_down = 16'(1) << 0;
    run(6 * 16);
    chk("t4_flags", 16'(flags_seen - f0), 16'd1);
    chk("t4_value", 16'(value), 16'h1);
    keys_down = '0;
    run(5 * 16);

    // 5. Rollover "A" -> "A"+"B" -> "B"
    f0 = flags_seen;
    keys_down = 16'(1) << 3;
    run(6 * 16);
    chk("t5_value", 16'(value), 16'hA);
    keys_down = keys_down | (16'(1) << 7);
    run(4 * 16);
    keys_down = 16'(1) << 7;
    run(4 * 16);
    chk("t5_flags", 16'(flags_seen - f0), 16'd1);
    chk("t5_held", 16'(key_held), 16'h1);
    keys_down = '0;
    run(5 * 16);
    chk("t5_released", 16'(key_held), 16'h0);

    // 6. Reset two frames into a press of "0"
    keys_down = 16'(1) << 13;
    w = 0;
    while (m_run != 2 && w < 200) begin
      tick();
      w++;
    end
    chk("t6_reach_chk2", 16'(w < 200), 16'h1);
    run(4);
    rst = 1'b0;
    run(3);
    chk("t6_rst_value", 16'(value), 16'h0);
    chk("t6_rst_held", 16'(key_held), 16'h0);
    chk("t6_rst_col", 16'(col), 16'h000E);
    rst = 1'b1;
    f0 = flags_seen;
    run(47);
    chk("t6_no_early_flag", 16'(flags_seen - f0), 16'd0);
    run(5);
    chk("t6_flags", 16'(flags_seen - f0), 16'd1);
    chk("t6_value", 16'(value), 16'h0);
    chk("t6_held", 16'(key_held), 16'h1);
    keys_down = '0;
    run(5 * 16);

    // 7. Random key patterns and occasional resets
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       keys_down = '0;
        1, 2:    keys_down = 16'(1) << $urandom_range(0, 15);
        default: keys_down = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        run(2);
        rst = 1'b1;
      end
      run(int'($urandom_range(8, 80)));
    end
    keys_down = '0;
    run(5 * 16);
    chk("final_held", 16'(key_held), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
